// File: rtl/lfsr_pkg.sv
// Shared types and constants for the round-robin LFSR scheduler.
// Tap masks follow the XAPP052 maximal-length table, bit (t-1) set for tap t.
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  localparam int LFSR_RESET_VAL = 1;

  function automatic logic [31:0] tap_bit(input int t);
    return 32'h1 << (t - 1);
  endfunction

  function automatic logic [31:0] lfsr_taps(input int n);
    case (n)
      3:       return tap_bit(3)  | tap_bit(2);
      4:       return tap_bit(4)  | tap_bit(3);
      5:       return tap_bit(5)  | tap_bit(3);
      6:       return tap_bit(6)  | tap_bit(5);
      7:       return tap_bit(7)  | tap_bit(6);
      8:       return tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
      9:       return tap_bit(9)  | tap_bit(5);
      10:      return tap_bit(10) | tap_bit(7);
      11:      return tap_bit(11) | tap_bit(9);
      12:      return tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13:      return tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14:      return tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15:      return tap_bit(15) | tap_bit(14);
      16:      return tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17:      return tap_bit(17) | tap_bit(14);
      18:      return tap_bit(18) | tap_bit(11);
      19:      return tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20:      return tap_bit(20) | tap_bit(17);
      21:      return tap_bit(21) | tap_bit(19);
      22:      return tap_bit(22) | tap_bit(21);
      23:      return tap_bit(23) | tap_bit(18);
      24:      return tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25:      return tap_bit(25) | tap_bit(22);
      26:      return tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      27:      return tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
      28:      return tap_bit(28) | tap_bit(25);
      29:      return tap_bit(29) | tap_bit(27);
      30:      return tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      31:      return tap_bit(31) | tap_bit(28);
      32:      return tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// N-bit XNOR-feedback LFSR register: shifts left, new LSB is XNOR of the taps.
// The all-ones state is the lock-up state; callers must never load it.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] TAP_MASK = N'(lfsr_taps(N));

  logic fb;
  assign fb = ~^(q & TAP_MASK);

  // NOTE: sequential state is written with <= only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst)       q <= N'(LFSR_RESET_VAL);
    else if (load) q <= load_val;
    else if (en)   q <= {q[N-2:0], fb};
  end

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one LFSR among REQ burst requesters.
// Optional LFSR_SCHED_STATS_EN adds a 32-bit accepted-word counter output.
module lfsr_rr_sched
  import lfsr_pkg::*;
#(
  parameter int N     = 16,
  parameter int REQ   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ-1:0]       req,
  input  logic [REQ*CNT_W-1:0] len,
  input  logic                 seed_load,
  input  logic [N-1:0]         seed,
  input  logic                 data_ready,
  output logic [REQ-1:0]       gnt,
  output logic                 data_valid,
  output logic [N-1:0]         data,
  output logic [REQ-1:0]       done,
  output logic                 busy
`ifdef LFSR_SCHED_STATS_EN
  ,
  output logic [31:0]          words_total
`endif
);

  localparam int IW = $clog2(REQ);

  sched_state_t     state;
  logic [IW-1:0]    ptr, cur, sel, cand;
  logic [CNT_W-1:0] remaining, sel_len;
  logic             handshake, lfsr_load;
  logic [N-1:0]     load_val;

  assign handshake = data_valid & data_ready;
  assign lfsr_load = (state == IDLE) & seed_load;
  // An all-ones seed would lock the generator up, so it is replaced.
  assign load_val  = (&seed) ? N'(LFSR_RESET_VAL) : seed;

  // NOTE: every variable gets a default before the loop so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel     = '0;
    cand    = '0;
    sel_len = '0;
    // Scan downward so the requester closest after ptr is written last.
    for (int i = REQ; i >= 1; i--) begin
      cand = IW'((int'(ptr) + i) % REQ);
      if (req[cand]) sel = cand;
    end
    for (int k = 0; k < REQ; k++) begin
      if (IW'(k) == sel) sel_len = len[k*CNT_W +: CNT_W];
    end
  end

  lfsr_step #(.N(N)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (handshake),
    .load     (lfsr_load),
    .load_val (load_val),
    .q        (data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IW'(REQ - 1);
      cur        <= '0;
      remaining  <= '0;
      gnt        <= '0;
      data_valid <= 1'b0;
      done       <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!seed_load && |req) begin
            cur       <= sel;
            remaining <= sel_len;
            busy      <= 1'b1;
            if (sel_len == '0) begin
              state <= DONE;
              done  <= REQ'(1) << sel;
            end else begin
              state      <= RUN;
              gnt        <= REQ'(1) << sel;
              data_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!req[cur]) begin
            // Abort: the LFSR still steps on a same-cycle handshake.
            state      <= IDLE;
            ptr        <= cur;
            gnt        <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (handshake) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state      <= DONE;
              gnt        <= '0;
              data_valid <= 1'b0;
              done       <= REQ'(1) << cur;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          ptr   <= cur;
          done  <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LFSR_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)            words_total <= '0;
    else if (handshake) words_total <= words_total + 32'd1;
  end
`endif

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Self-checking bench for lfsr_rr_sched: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_lfsr_rr_sched;

  localparam int N = 16, REQ = 4, CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [REQ-1:0]       req;
  logic [REQ*CNT_W-1:0] len;
  logic                 seed_load;
  logic [N-1:0]         seed;
  logic                 data_ready;
  logic [REQ-1:0]       gnt, done;
  logic                 data_valid, busy;
  logic [N-1:0]         data;
`ifdef LFSR_SCHED_STATS_EN
  logic [31:0]          words_total;
`endif

  always #5 clk = ~clk;

  lfsr_rr_sched #(.N(N), .REQ(REQ), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .len        (len),
    .seed_load  (seed_load),
    .seed       (seed),
    .data_ready (data_ready),
    .gnt        (gnt),
    .data_valid (data_valid),
    .data       (data),
    .done       (done),
    .busy       (busy)
`ifdef LFSR_SCHED_STATS_EN
    ,
    .words_total(words_total)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Next value of the 16-bit stream, straight from the tap list 15,14,12,3.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    int taps[4] = '{15, 14, 12, 3};
    logic x = 1'b0;
    for (int i = 0; i < 4; i++) x = x ^ s[taps[i]];
    return {s[14:0], ~x};
  endfunction

  function automatic int rr_pick(input int ptr, input logic [REQ-1:0] r);
    for (int i = 1; i <= REQ; i++) begin
      if (r[(ptr + i) % REQ]) return (ptr + i) % REQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; len = '0; seed_load = 1'b0; seed = '0; data_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [REQ-1:0]       req;
    logic [REQ*CNT_W-1:0] len;
    logic                 rdy;
    logic                 sl;
    logic [N-1:0]         seed;
    logic [REQ-1:0]       gnt;
    logic                 dv;
    logic [N-1:0]         data;
    logic [REQ-1:0]       done;
    logic                 busy;
  } vec_t;

  vec_t vt[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]    m;
    logic [REQ-1:0] m_gnt, m_done, n_gnt, n_done;
    logic           m_dv, n_dv, prev_idle, hs;
    int             m_ptr, cur, exp_len, words, hsn, ng, k;
    int             order[5], when[5];
    logic [31:0]    m_words;
    logic           got_done;

    //      req      len           rdy sl  seed      gnt      dv  data      done     busy
    vt[0]  = '{4'b0001, 32'h0000_0002, 1, 0, 16'h0000, 4'b0001, 1, 16'h0001, 4'b0000, 1};
    vt[1]  = '{4'b0001, 32'h0000_0002, 1, 0, 16'h0000, 4'b0001, 1, 16'h0003, 4'b0000, 1};
    vt[2]  = '{4'b0001, 32'h0000_0002, 1, 0, 16'h0000, 4'b0000, 0, 16'h0007, 4'b0001, 1};
    vt[3]  = '{4'b0000, 32'h0000_0000, 1, 0, 16'h0000, 4'b0000, 0, 16'h0007, 4'b0000, 0};
    vt[4]  = '{4'b0010, 32'h0000_0000, 1, 0, 16'h0000, 4'b0000, 0, 16'h0007, 4'b0010, 1};
    vt[5]  = '{4'b0000, 32'h0000_0000, 1, 0, 16'h0000, 4'b0000, 0, 16'h0007, 4'b0000, 0};
    vt[6]  = '{4'b0100, 32'h0001_0000, 1, 1, 16'hFFFF, 4'b0000, 0, 16'h0001, 4'b0000, 0};
    vt[7]  = '{4'b0100, 32'h0001_0000, 1, 0, 16'h0000, 4'b0100, 1, 16'h0001, 4'b0000, 1};
    vt[8]  = '{4'b0100, 32'h0001_0000, 0, 0, 16'h0000, 4'b0100, 1, 16'h0001, 4'b0000, 1};
    vt[9]  = '{4'b0100, 32'h0001_0000, 1, 0, 16'h0000, 4'b0000, 0, 16'h0003, 4'b0100, 1};
    vt[10] = '{4'b0000, 32'h0000_0000, 1, 0, 16'h0000, 4'b0000, 0, 16'h0003, 4'b0000, 0};

    // Reset state
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_dv", data_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 16'h0001);
`ifdef LFSR_SCHED_STATS_EN
    check("rst_words", words_total, 0);
`endif

    // First burst, zero length, seed handling, single-cycle stall
    for (int i = 0; i < 11; i++) begin
      req = vt[i].req; len = vt[i].len; data_ready = vt[i].rdy;
      seed_load = vt[i].sl; seed = vt[i].seed;
      tick();
      check($sformatf("v%0d_gnt", i), gnt, vt[i].gnt);
      check($sformatf("v%0d_dv", i), data_valid, vt[i].dv);
      check($sformatf("v%0d_data", i), data, vt[i].data);
      check($sformatf("v%0d_done", i), done, vt[i].done);
      check($sformatf("v%0d_busy", i), busy, vt[i].busy);
    end

    // Round-robin order and inter-burst spacing
    do_reset();
    req = 4'hF; len = 32'h0101_0101; data_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      tick();
      if (gnt != 0) begin
        for (int b = 0; b < REQ; b++) if (gnt[b]) order[ng] = b;
        when[ng] = c;
        ng++;
      end
    end
    check("rr_grants", ng, 5);
    for (int i = 0; i < ng; i++) begin
      check($sformatf("rr_order%0d", i), order[i], i % REQ);
      if (i > 0) check($sformatf("rr_gap%0d", i), when[i] - when[i-1], 3);
    end
    req = '0; tick(); tick();

    // Backpressure: five stalled cycles mid-burst
    do_reset();
    m = 16'h0001; hsn = 0; got_done = 1'b0;
    req = 4'b0001; len = 32'd4; data_ready = 1'b1;
    tick();
    check("bp_gnt", gnt, 4'b0001);
    for (int c = 0; c < 20; c++) begin
      data_ready = (c < 1 || c >= 6);
      if (data_valid && data_ready) begin hsn++; m = ref_next(m); end
      tick();
      check($sformatf("bp_data%0d", c), data, m);
      if (done != 0) begin got_done = 1'b1; break; end
    end
    check("bp_done_seen", got_done, 1);
    check("bp_done", done, 4'b0001);
    check("bp_handshakes", hsn, 4);
    req = '0; tick(); tick();

    // Abort mid-burst: no done, next grant rotates, stream continues
    do_reset();
    m = 16'h0001;
    req = 4'b0011; len = 32'h0000_0206; data_ready = 1'b1;
    tick();
    check("ab_gnt0", gnt, 4'b0001);
    tick(); m = ref_next(m);
    tick(); m = ref_next(m);
    req = 4'b0010;
    tick(); m = ref_next(m);
    check("ab_gnt_off", gnt, 0);
    check("ab_no_done", done, 0);
    check("ab_data", data, m);
    tick();
    check("ab_next_gnt", gnt, 4'b0010);
    check("ab_next_data", data, m);
    tick(); m = ref_next(m);
    tick(); m = ref_next(m);
    check("ab_done1", done, 4'b0010);
    check("ab_data_end", data, m);
    req = '0; tick(); tick();

    // Reset mid-burst
    do_reset();
    req = 4'b0001; len = 32'd10; data_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("mr_gnt", gnt, 0);
    check("mr_dv", data_valid, 0);
    check("mr_done", done, 0);
    check("mr_busy", busy, 0);
    check("mr_data", data, 16'h0001);
`ifdef LFSR_SCHED_STATS_EN
    check("mr_words", words_total, 0);
`endif
    rst = 1'b0;
    tick();
    check("mr_regrant", gnt, 4'b0001);
    check("mr_regrant_data", data, 16'h0001);
    req = '0; tick(); tick();

    // Randomized run against the transaction-level model
    do_reset();
    m = 16'h0001; m_ptr = REQ - 1; cur = 0; exp_len = 0; words = 0; m_words = 0;
    m_gnt = '0; m_dv = 1'b0; m_done = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int q = 0; q < REQ; q++) begin
        if (!req[q]) begin
          if ($urandom_range(3) == 0) begin
            req[q] = 1'b1;
            len[q*CNT_W +: CNT_W] = CNT_W'($urandom_range(5));
          end
        end else if (m_gnt[q] && $urandom_range(15) == 0) req[q] = 1'b0;
        else if (m_done[q] && $urandom_range(1) == 0) req[q] = 1'b0;
      end
      data_ready = ($urandom_range(3) != 0);
      seed_load  = ($urandom_range(19) == 0);
      seed       = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
      tick();

      prev_idle = (m_gnt == 0) && (m_done == 0);
      hs = m_dv && data_ready;
      n_gnt = '0; n_dv = 1'b0; n_done = '0;
      if (prev_idle) begin
        if (seed_load) m = (seed == 16'hFFFF) ? 16'h0001 : seed;
        else if (req != 0) begin
          k = rr_pick(m_ptr, req);
          cur = k; words = 0;
          exp_len = int'(len[k*CNT_W +: CNT_W]);
          if (exp_len == 0) begin n_done = 4'(1 << k); m_ptr = k; end
          else begin n_gnt = 4'(1 << k); n_dv = 1'b1; end
        end
      end else if (m_gnt != 0) begin
        if (hs) begin m = ref_next(m); words++; m_words++; end
        if (!req[cur]) m_ptr = cur;
        else if (hs && words == exp_len) begin n_done = 4'(1 << cur); m_ptr = cur; end
        else begin n_gnt = 4'(1 << cur); n_dv = 1'b1; end
      end
      m_gnt = n_gnt; m_dv = n_dv; m_done = n_done;

      check("rnd_gnt", gnt, m_gnt);
      check("rnd_dv", data_valid, m_dv);
      check("rnd_done", done, m_done);
      check("rnd_busy", busy, (m_gnt != 0) || (m_done != 0));
      check("rnd_data", data, m);
`ifdef LFSR_SCHED_STATS_EN
      check("rnd_words", words_total, m_words);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
